// File: rtl/terminal_pkg.sv
// Shared terminal-path definitions: sequencer state encoding, ASCII control characters
// and a clog2 helper that never returns a zero width.
package terminal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fsm_msg_tx_msg_rom.sv
// msg_rom: combinational index -> character lookup over the packed message string.
// Build option FSM_MSG_CRLF_EN appends CR and LF after the last message character.
module msg_rom
  import terminal_pkg::*;
#(
  parameter int                        CHAR_W  = 8,
  parameter int                        MSG_LEN = 4,
  parameter logic [CHAR_W*MSG_LEN-1:0] MSG     = "yoye",
  parameter int                        IDX_W   = 2
) (
  input  logic [IDX_W-1:0]  i_idx,
  output logic [CHAR_W-1:0] o_char
);

`ifdef FSM_MSG_CRLF_EN
  localparam int N_CHARS = MSG_LEN + 2;
`else
  localparam int N_CHARS = MSG_LEN;
`endif

  logic [CHAR_W-1:0] w_table [N_CHARS];

  // Character 0 sits in the most significant slot of the packed string.
  genvar gi;
  generate
    for (gi = 0; gi < MSG_LEN; gi++) begin : g_msg
      assign w_table[gi] = MSG[CHAR_W*(MSG_LEN-gi)-1 -: CHAR_W];
    end
  endgenerate

`ifdef FSM_MSG_CRLF_EN
  localparam logic [7:0] W_CR = CHR_CR;
  localparam logic [7:0] W_LF = CHR_LF;
  assign w_table[MSG_LEN]   = W_CR[CHAR_W-1:0];
  assign w_table[MSG_LEN+1] = W_LF[CHAR_W-1:0];
`endif

  always_comb begin
    o_char = '0;
    if (int'(i_idx) < N_CHARS) begin
      o_char = w_table[i_idx];
    end
  end

endmodule

// File: rtl/fsm_msg_tx.sv
// fsm_msg_tx: sends a fixed message, optionally repeated, through uart_tx one character
// per sttx/eot handshake. Build option FSM_MSG_CRLF_EN adds CR/LF after each repetition.
module fsm_msg_tx
  import terminal_pkg::*;
#(
  parameter int                        CHAR_W  = 8,
  parameter int                        MSG_LEN = 4,
  parameter logic [CHAR_W*MSG_LEN-1:0] MSG     = "yoye",
  parameter int                        REPEAT  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              eot_i,
  output logic              sttx_o,
  output logic [CHAR_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o
);

`ifdef FSM_MSG_CRLF_EN
  localparam int LAST = MSG_LEN + 1;
`else
  localparam int LAST = MSG_LEN - 1;
`endif
  localparam int               IDX_W    = clog2_min1(LAST + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST);
  localparam logic [7:0]       LAST_REP = 8'(REPEAT - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_next;
  logic [7:0]        r_rep;
  logic [7:0]        w_rep_next;
  logic [CHAR_W-1:0] w_char;

  msg_rom #(
    .CHAR_W  (CHAR_W),
    .MSG_LEN (MSG_LEN),
    .MSG     (MSG),
    .IDX_W   (IDX_W)
  ) u_rom (
    .i_idx  (r_idx),
    .o_char (w_char)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_rep   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_rep   <= w_rep_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_rep_next   = r_rep;
    sttx_o       = 1'b0;
    data_o       = '0;
    busy_o       = 1'b1;
    done_o       = 1'b0;

    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          w_state_next = SEND;
          w_idx_next   = '0;
          w_rep_next   = '0;
        end
      end
      SEND: begin
        sttx_o       = 1'b1;
        data_o       = w_char;
        w_state_next = abort_i ? IDLE : WAIT;
      end
      WAIT: begin
        data_o = w_char;
        // Abort takes priority over a coincident end-of-transmission.
        if (abort_i) begin
          w_state_next = IDLE;
        end else if (eot_i) begin
          if (r_idx < LAST_IDX) begin
            w_idx_next   = r_idx + IDX_W'(1);
            w_state_next = SEND;
          end else if (r_rep < LAST_REP) begin
            w_idx_next   = '0;
            w_rep_next   = r_rep + 8'd1;
            w_state_next = SEND;
          end else begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        done_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        busy_o       = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_msg_tx.sv
// Scoreboard bench for fsm_msg_tx: a default instance ("yoye") and a REPEAT=2 "abc" instance.
module tb_fsm_msg_tx;

  localparam int DONE_TOK = -1;
`ifdef FSM_MSG_CRLF_EN
  localparam int N_A = 6;
  localparam int N_B = 10;
`else
  localparam int N_A = 4;
  localparam int N_B = 6;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, abort_a = 1'b0, eot_a = 1'b0;
  logic       sttx_a, busy_a, done_a;
  logic [7:0] data_a;
  logic       start_b = 1'b0, abort_b = 1'b0, eot_b = 1'b0;
  logic       sttx_b, busy_b, done_b;
  logic [7:0] data_b;

  fsm_msg_tx dut_a (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start_a),
    .abort_i (abort_a),
    .eot_i   (eot_a),
    .sttx_o  (sttx_a),
    .data_o  (data_a),
    .busy_o  (busy_a),
    .done_o  (done_a)
  );

  fsm_msg_tx #(
    .CHAR_W  (8),
    .MSG_LEN (3),
    .MSG     (24'h616263),
    .REPEAT  (2)
  ) dut_b (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start_b),
    .abort_i (abort_b),
    .eot_i   (eot_b),
    .sttx_o  (sttx_b),
    .data_o  (data_b),
    .busy_o  (busy_b),
    .done_o  (done_b)
  );

  int checks = 0;
  int errors = 0;
  int q_a[$];
  int q_b[$];
  logic [7:0] held [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic get_sttx(input bit sel); return sel ? sttx_b : sttx_a; endfunction
  function automatic logic get_busy(input bit sel); return sel ? busy_b : busy_a; endfunction
  function automatic logic get_done(input bit sel); return sel ? done_b : done_a; endfunction
  function automatic logic [7:0] get_data(input bit sel); return sel ? data_b : data_a; endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask
  task automatic set_eot(input bit sel, input logic v);
    if (sel) eot_b = v; else eot_a = v;
  endtask

  task automatic push(input bit sel, input int v);
    if (sel) q_b.push_back(v); else q_a.push_back(v);
  endtask

  // Expected characters for the default "yoye" message, first n of them.
  task automatic push_msg_a(input int n, input bit with_done);
    int m[$];
    m = '{'h79, 'h6F, 'h79, 'h65};
`ifdef FSM_MSG_CRLF_EN
    m.push_back('h0D);
    m.push_back('h0A);
`endif
    for (int i = 0; i < n; i++) push(0, m[i]);
    if (with_done) push(0, DONE_TOK);
  endtask

  task automatic push_msg_b();
    int m[$];
    m = '{'h61, 'h62, 'h63};
`ifdef FSM_MSG_CRLF_EN
    m.push_back('h0D);
    m.push_back('h0A);
`endif
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < m.size(); i++) push(1, m[i]);
    push(1, DONE_TOK);
  endtask

  // Monitor: one transaction line per sttx_o / done_o event, compared against the queue.
  task automatic mon(input bit sel, input logic s, input logic b, input logic d, input logic [7:0] dt);
    int head;
    int qs;
    qs = sel ? q_b.size() : q_a.size();
    if (s) begin
      check("sttx_while_busy", b, 1);
      if (qs == 0) begin
        check("unexpected_sttx", s, 0);
      end else begin
        head = sel ? q_b.pop_front() : q_a.pop_front();
        $display("dut_%s sttx data=0x%02h expected=0x%02h", sel ? "b" : "a", dt, head[7:0]);
        check("sttx_data", dt, head);
        held[sel] = dt;
      end
    end else if (d) begin
      if (qs == 0) begin
        check("unexpected_done", d, 0);
      end else begin
        head = sel ? q_b.pop_front() : q_a.pop_front();
        $display("dut_%s done", sel ? "b" : "a");
        check("done_with_chars_pending", (head == DONE_TOK) ? 0 : head, 0);
      end
    end else if (b) begin
      check("data_hold_in_wait", dt, held[sel]);
    end else begin
      check("idle_data_zero", dt, 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, sttx_a, busy_a, done_a, data_a);
    mon(1, sttx_b, busy_b, done_b, data_b);
  end

  task automatic start_msg(input bit sel);
    @(posedge clk); #1 set_start(sel, 1'b1);
    @(posedge clk); #1 set_start(sel, 1'b0);
    check("start_latency", get_sttx(sel), 1);
  endtask

  task automatic wait_sttx(input bit sel, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (get_sttx(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("sttx_timeout", get_sttx(sel), 1);
  endtask

  // Acts as uart_tx for n characters; mode 1 uses random eot delays, stray pulses start_i.
  task automatic serve(input bit sel, input int n, input bit mode, input bit stray, input bit fin);
    bit ok;
    int d;
    for (int i = 0; i < n; i++) begin
      wait_sttx(sel, ok);
      if (!ok) return;
      if (stray && i == 0) set_start(sel, 1'b1);
      d = mode ? int'($urandom_range(1, 40)) : 10;
      @(posedge clk); #1 set_start(sel, 1'b0);
      if (stray && i == 1) set_start(sel, 1'b1);
      for (int k = 1; k < d; k++) begin
        @(posedge clk); #1 set_start(sel, 1'b0);
      end
      set_eot(sel, 1'b1);
      @(posedge clk); #1 set_eot(sel, 1'b0);
      set_start(sel, 1'b0);
      if (fin && i == n - 1) begin
        check("done_after_last_eot", get_done(sel), 1);
        if (stray) set_start(sel, 1'b1);
        @(posedge clk); #1 set_start(sel, 1'b0);
        check("busy_falls_after_done", get_busy(sel), 0);
      end else if (i < n - 1) begin
        check("eot_to_sttx_latency", get_sttx(sel), 1);
      end
    end
  endtask

  task automatic settle_and_drain(input bit sel);
    repeat (6) @(posedge clk);
    #1 check("scoreboard_drained", sel ? q_b.size() : q_a.size(), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    held[0] = '0;
    held[1] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_sttx", sttx_a, 0);
    check("reset_data", data_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: basic message, eot 10 cycles after each sttx
    push_msg_a(N_A, 1);
    start_msg(0);
    serve(0, N_A, 0, 0, 1);
    settle_and_drain(0);

    // 2: random eot delays
    for (int r = 0; r < 2; r++) begin
      push_msg_a(N_A, 1);
      start_msg(0);
      serve(0, N_A, 1, 0, 1);
      settle_and_drain(0);
    end

    // 3: start_i pulsed in SEND, WAIT and DONE is ignored
    push_msg_a(N_A, 1);
    start_msg(0);
    serve(0, N_A, 0, 1, 1);
    settle_and_drain(0);

    // 4: abort together with eot during WAIT of char 2
    push_msg_a(3, 0);
    start_msg(0);
    serve(0, 2, 0, 0, 0);
    wait_sttx(0, ok);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1 abort_a = 1'b1; eot_a = 1'b1;
    @(posedge clk); #1 abort_a = 1'b0; eot_a = 1'b0;
    check("abort_to_idle", busy_a, 0);
    check("abort_no_done", done_a, 0);
    settle_and_drain(0);
    push_msg_a(N_A, 1);
    start_msg(0);
    serve(0, N_A, 0, 0, 1);
    settle_and_drain(0);

    // 5: REPEAT=2, "abc"
    push_msg_b();
    start_msg(1);
    serve(1, N_B, 0, 0, 1);
    settle_and_drain(1);

    // 6: asynchronous reset mid-WAIT
    push_msg_a(2, 0);
    start_msg(0);
    serve(0, 1, 0, 0, 0);
    wait_sttx(0, ok);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_sttx", sttx_a, 0);
    check("async_rst_data", data_a, 0);
    check("async_rst_busy", busy_a, 0);
    check("async_rst_done", done_a, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    settle_and_drain(0);
    push_msg_a(N_A, 1);
    start_msg(0);
    serve(0, N_A, 0, 0, 1);
    settle_and_drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
